// File: rtl/router_out_reader_if.sv
// Bundle between one router output channel reader, its channel FIFO/sync logic and the byte sink.
interface router_out_reader_if #(
  parameter int CNT_W = 16
);
  logic             vld_out;
  logic             soft_reset;
  logic [7:0]       fifo_dout;
  logic             sink_ready;
  logic             read_enb;
  logic [7:0]       pkt_data;
  logic             pkt_vld;
  logic             pkt_sop;
  logic             pkt_eop;
  logic             pkt_err;
  logic             pkt_abort;
  logic             busy;
  logic [CNT_W-1:0] pkt_count;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] abort_count;

  modport master (
    input  vld_out, soft_reset, fifo_dout, sink_ready,
    output read_enb, pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_err, pkt_abort,
           busy, pkt_count, err_count, abort_count
  );

  modport slave (
    output vld_out, soft_reset, fifo_dout, sink_ready,
    input  read_enb, pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_err, pkt_abort,
           busy, pkt_count, err_count, abort_count
  );
endinterface

// File: rtl/router_out_reader.sv
// Pops one router channel FIFO, frames header/payload/parity to the sink with sop/eop/err.
// Bytes appear 1 cycle after read_enb; sink_ready and vld_out gate issue, soft_reset aborts the packet.
module router_out_reader #(
  parameter int START_DLY = 0,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  router_out_reader_if.master io
);

  typedef enum logic [2:0] {S_IDLE, S_DLY, S_HDR_RD, S_HDR_WT, S_BODY, S_DRAIN} state_t;

  localparam logic [4:0] DLY_INIT = 5'(START_DLY);
  localparam bit         NO_DLY   = (START_DLY == 0);

  state_t           state_q, state_d;
  logic [4:0]       dly_q, dly_d;
  logic [6:0]       rem_q, rem_d;
  logic [6:0]       iss_q, iss_d;
  logic [7:0]       par_q, par_d;
  logic             infl_q, infl_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] abt_cnt_q, abt_cnt_d;

  logic       rd;
  logic       can_rd;
  logic       abort_now;
  logic       out_vld;
  logic       chk_err;
  logic [6:0] iss_inc;

  assign can_rd    = io.vld_out & io.sink_ready;
  assign abort_now = io.soft_reset & (state_q != S_IDLE);
  // A byte already in flight when the channel is flushed is dropped, not shown.
  assign out_vld   = infl_q & ~abort_now;
  assign chk_err   = eop_q & (par_q != io.fifo_dout);
  assign iss_inc   = iss_q + 7'd1;

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    rem_d     = rem_q;
    iss_d     = iss_q;
    par_d     = par_q;
    infl_d    = 1'b0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    abort_d   = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    abt_cnt_d = abt_cnt_q;
    rd        = 1'b0;

    if (abort_now) begin
      state_d   = S_IDLE;
      abort_d   = 1'b1;
      abt_cnt_d = abt_cnt_q + CNT_W'(1);
    end else begin
      if (infl_q) begin
        if (sop_q) begin
          par_d = io.fifo_dout;
        end else if (!eop_q) begin
          par_d = par_q ^ io.fifo_dout;
        end
        if (eop_q) begin
          pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          if (chk_err) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
        end
      end

      unique case (state_q)
        S_IDLE: begin
          if (io.vld_out && !io.soft_reset) begin
            // With no start delay the header read issues from IDLE so back-to-back packets lose no cycle.
            if (NO_DLY) begin
              if (io.sink_ready) begin
                rd      = 1'b1;
                sop_d   = 1'b1;
                state_d = S_HDR_WT;
              end else begin
                state_d = S_HDR_RD;
              end
            end else begin
              dly_d   = DLY_INIT;
              state_d = S_DLY;
            end
          end
        end
        S_DLY: begin
          if (dly_q == 5'd0) begin
            state_d = S_HDR_RD;
          end else begin
            dly_d = dly_q - 5'd1;
          end
        end
        S_HDR_RD: begin
          if (can_rd) begin
            rd      = 1'b1;
            sop_d   = 1'b1;
            state_d = S_HDR_WT;
          end
        end
        S_HDR_WT: begin
          if (infl_q) begin
            rem_d   = {1'b0, io.fifo_dout[7:2]} + 7'd1;
            iss_d   = 7'd0;
            state_d = S_BODY;
          end
        end
        S_BODY: begin
          if (can_rd && (iss_q < rem_q)) begin
            rd    = 1'b1;
            iss_d = iss_inc;
            if (iss_inc == rem_q) begin
              eop_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (infl_q) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      infl_d = rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      dly_q     <= '0;
      rem_q     <= '0;
      iss_q     <= '0;
      par_q     <= '0;
      infl_q    <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      abort_q   <= 1'b0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
      abt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      rem_q     <= rem_d;
      iss_q     <= iss_d;
      par_q     <= par_d;
      infl_q    <= infl_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      abort_q   <= abort_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
      abt_cnt_q <= abt_cnt_d;
    end
  end

  assign io.read_enb    = rd;
  assign io.pkt_data    = out_vld ? io.fifo_dout : 8'h00;
  assign io.pkt_vld     = out_vld;
  assign io.pkt_sop     = out_vld & sop_q;
  assign io.pkt_eop     = out_vld & eop_q;
  assign io.pkt_err     = out_vld & chk_err;
  assign io.pkt_abort   = abort_q;
  assign io.busy        = (state_q != S_IDLE);
  assign io.pkt_count   = pkt_cnt_q;
  assign io.err_count   = err_cnt_q;
  assign io.abort_count = abt_cnt_q;

endmodule
